// File: rtl/freq_counter_autorange.sv
// Gated frequency counter: counts synchronised rising edges of signal_in over a
// programmable window of clk cycles and reports a clipped or auto-ranged result.
module freq_counter_autorange #(
  parameter int OUT_W       = 8,
  parameter int CNT_W       = 24,
  parameter int PERIOD_W    = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                signal_in,
  input  logic [PERIOD_W-1:0] gate_period,
  input  logic                auto_range,
  output logic [OUT_W-1:0]    freq_out,
  output logic [4:0]          freq_shift,
  output logic                freq_valid,
  output logic                overflow
);

  localparam int SMAX = CNT_W - OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OUT_MAX = {{(CNT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [PERIOD_W-1:0]    gate_cnt_q, gate_cnt_d, g_q, g_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic [OUT_W-1:0]       fout_q, fout_d;
  logic [4:0]             fsh_q, fsh_d;
  logic                   fvld_q, fvld_d, fov_q, fov_d;

  logic                   sig_rise, at_max, last_cyc, sat_fin, clip;
  logic [PERIOD_W-1:0]    gp_eff, g_cur;
  logic [CNT_W-1:0]       final_cnt, shifted;
  logic [4:0]             shift_c;

  // Sync chain runs regardless of enable so re-enable sees a settled input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign gp_eff    = (gate_period == '0) ? {{(PERIOD_W-1){1'b0}}, 1'b1} : gate_period;
  // Window length is taken live in the first cycle, latched copy afterwards.
  assign g_cur     = (gate_cnt_q == '0) ? gp_eff : g_q;
  assign last_cyc  = (gate_cnt_q == g_cur - 1'b1);
  assign at_max    = (edge_cnt_q == CNT_MAX);
  assign final_cnt = (sig_rise && !at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
  assign sat_fin   = sat_q | (sig_rise & at_max);
  assign clip      = (final_cnt > OUT_MAX);

  always_comb begin
    shift_c = 5'(SMAX);
    for (int i = SMAX - 1; i >= 0; i--) begin
      if ((final_cnt >> i) <= OUT_MAX) shift_c = 5'(i);
    end
    shifted = final_cnt >> shift_c;
  end

  always_comb begin
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    g_d        = g_q;
    fout_d     = fout_q;
    fsh_d      = fsh_q;
    fov_d      = fov_q;
    fvld_d     = 1'b0;
    if (!enable) begin
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      sat_d      = 1'b0;
    end else begin
      if (gate_cnt_q == '0) g_d = gp_eff;
      if (last_cyc) begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        fvld_d     = 1'b1;
        if (auto_range) begin
          fout_d = shifted[OUT_W-1:0];
          fsh_d  = shift_c;
          fov_d  = sat_fin;
        end else begin
          fout_d = clip ? {OUT_W{1'b1}} : final_cnt[OUT_W-1:0];
          fsh_d  = 5'd0;
          fov_d  = sat_fin | clip;
        end
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = final_cnt;
        sat_d      = sat_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      g_q        <= '0;
      fout_q     <= '0;
      fsh_q      <= '0;
      fvld_q     <= 1'b0;
      fov_q      <= 1'b0;
    end else begin
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      g_q        <= g_d;
      fout_q     <= fout_d;
      fsh_q      <= fsh_d;
      fvld_q     <= fvld_d;
      fov_q      <= fov_d;
    end
  end

  assign freq_out   = fout_q;
  assign freq_shift = fsh_q;
  assign freq_valid = fvld_q;
  assign overflow   = fov_q;

endmodule
